// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM state type and helpers for the load/store unit.
package load_store_unit_pkg;

  localparam logic [2:0] DATA_SIZE_BYTE        = 3'd0;
  localparam logic [2:0] DATA_SIZE_HALF_WORD   = 3'd1;
  localparam logic [2:0] DATA_SIZE_WORD        = 3'd2;
  localparam logic [2:0] DATA_SIZE_U_BYTE      = 3'd4;
  localparam logic [2:0] DATA_SIZE_U_HALF_WORD = 3'd5;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  function automatic logic size_is_legal(input logic [2:0] size);
    return (size == DATA_SIZE_BYTE)      || (size == DATA_SIZE_HALF_WORD) ||
           (size == DATA_SIZE_WORD)      || (size == DATA_SIZE_U_BYTE)    ||
           (size == DATA_SIZE_U_HALF_WORD);
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: byte enables, store replication, load extraction
// and extension, plus misaligned/illegal classification of a size/offset pair.
module lsu_data_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  logic [15:0] lane;
  logic        sext;

  always_comb begin
    be         = '0;
    wdata_rep  = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    illegal    = !size_is_legal(size);
    lane       = 16'(rdata >> {offset, 3'b000});
    sext       = !size[2];
    case (size)
      DATA_SIZE_BYTE, DATA_SIZE_U_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane[7] & sext}}, lane[7:0]};
      end
      DATA_SIZE_HALF_WORD, DATA_SIZE_U_HALF_WORD: begin
        misaligned = offset[0];
        be         = 4'b0011 << offset;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{lane[15] & sext}}, lane[15:0]};
      end
      DATA_SIZE_WORD: begin
        misaligned = |offset;
        be         = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: classifies a core access, runs one byte-enabled memory
// transaction with req/ready handshake and timeout, returns extended load data.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   LSU_IDLE | no access outstanding; core_req classified combinationally
//   LSU_WAIT | mem_req held with registered attributes until ready/timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            core_req,
  input  logic            core_we,
  input  logic [2:0]      core_size,
  input  logic [XLEN-1:0] core_addr,
  input  logic [XLEN-1:0] core_wdata,
  output logic            core_stall,
  output logic            core_valid,
  output logic [XLEN-1:0] core_rdata,
  output logic            core_misaligned,
  output logic            core_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_q, state_d;
  logic [7:0] cnt_q;
  logic [2:0] size_q;
  logic [1:0] off_q;

  logic [2:0]      al_size;
  logic [1:0]      al_off;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_misaligned;
  logic            al_illegal;
  logic            in_idle;
  logic            accept;
  logic            timeout;

  // One aligner serves both phases: request attributes in IDLE, load extract in WAIT.
  assign in_idle = (state_q == LSU_IDLE);
  assign al_size = in_idle ? core_size : size_q;
  assign al_off  = in_idle ? core_addr[1:0] : off_q;

  lsu_data_align u_align (
    .size       (al_size),
    .offset     (al_off),
    .wdata      (core_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign accept  = in_idle && core_req && !al_illegal && !al_misaligned;
  assign timeout = (state_q == LSU_WAIT) && !mem_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    core_stall = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        core_stall = accept;
        if (accept) state_d = LSU_WAIT;
      end
      LSU_WAIT: begin
        core_stall = 1'b1;
        if (mem_ready || timeout) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_be          <= '0;
      mem_wdata       <= '0;
      core_valid      <= 1'b0;
      core_misaligned <= 1'b0;
      core_err        <= 1'b0;
      core_rdata      <= '0;
      cnt_q           <= '0;
      size_q          <= '0;
      off_q           <= '0;
    end else begin
      core_valid      <= 1'b0;
      core_misaligned <= 1'b0;
      core_err        <= 1'b0;
      if (in_idle) begin
        if (core_req && al_illegal) begin
          core_err <= 1'b1;
        end else if (core_req && al_misaligned) begin
          core_misaligned <= 1'b1;
        end else if (accept) begin
          mem_req   <= 1'b1;
          mem_we    <= core_we;
          mem_addr  <= {core_addr[XLEN-1:2], 2'b00};
          mem_be    <= al_be;
          mem_wdata <= al_wdata;
          size_q    <= core_size;
          off_q     <= core_addr[1:0];
          cnt_q     <= '0;
        end
      end else begin
        // Ready on the last timeout cycle still completes the access.
        if (mem_ready) begin
          mem_req    <= 1'b0;
          core_valid <= 1'b1;
          if (!mem_we) core_rdata <= al_rdata;
        end else if (timeout) begin
          mem_req  <= 1'b0;
          core_err <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios, then random
// accesses checked against a behavioural model of the access contract.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall, core_valid, core_misaligned, core_err;
  logic [31:0] core_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .core_req        (core_req),
    .core_we         (core_we),
    .core_size       (core_size),
    .core_addr       (core_addr),
    .core_wdata      (core_wdata),
    .core_stall      (core_stall),
    .core_valid      (core_valid),
    .core_rdata      (core_rdata),
    .core_misaligned (core_misaligned),
    .core_err        (core_err),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_be          (mem_be),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; delay = WAIT cycles before mem_ready (>= TMO means never).
  task automatic run_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    logic [1:0]  off;
    logic        ill, mis;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd, sh;
    off = addr[1:0];
    ill = !(size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = !ill && (((size == 3'd1 || size == 3'd5) && off[0]) || (size == 3'd2 && off != 2'd0));
    sh  = rdata >> (8 * int'(off));
    ebe = '0;
    ewd = '0;
    erd = '0;
    case (size)
      3'd0, 3'd4: begin ebe[off] = 1'b1; ewd = {4{wdata[7:0]}}; end
      3'd1, 3'd5: begin ebe[off] = 1'b1; ebe[off + 2'd1] = 1'b1; ewd = {2{wdata[15:0]}}; end
      3'd2:       begin ebe = 4'hF; ewd = wdata; end
      default: ;
    endcase
    case (size)
      3'd0: erd = 32'($signed(sh[7:0]));
      3'd4: erd = 32'(sh[7:0]);
      3'd1: erd = 32'($signed(sh[15:0]));
      3'd5: erd = 32'(sh[15:0]);
      default: erd = rdata;
    endcase

    @(negedge clk);
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wdata = wdata;
    mem_ready = 1'b0;
    #1;
    check("stall_req", 32'(core_stall), 32'(!(ill || mis)));
    check("memreq_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    if (ill || mis) begin
      core_req = 1'b0;
      #1;
      check("err_pulse", 32'(core_err), 32'(ill));
      check("mis_pulse", 32'(core_misaligned), 32'(mis));
      check("memreq_rej", 32'(mem_req), 32'd0);
      check("stall_rej", 32'(core_stall), 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      check("quiet_rej", 32'({core_err, core_misaligned, core_valid, mem_req}), 32'd0);
      mem_ready = 1'b0;
      return;
    end
    for (int n = 0; n < TMO; n++) begin
      check("memreq_wait", 32'(mem_req), 32'd1);
      check("stall_wait", 32'(core_stall), 32'd1);
      check("valid_wait", 32'(core_valid), 32'd0);
      check("addr", mem_addr, {addr[31:2], 2'b00});
      check("be", 32'(mem_be), 32'(ebe));
      check("wdata", mem_wdata, ewd);
      check("we", 32'(mem_we), 32'(we));
      if (n == delay) begin
        mem_ready = 1'b1; mem_rdata = rdata;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
      @(negedge clk);
      if (n == delay) break;
    end
    mem_ready = 1'b0;
    core_req  = 1'b0;
    #1;
    if (delay < TMO) begin
      if (!we) exp_rdata = erd;
      check("valid_done", 32'(core_valid), 32'd1);
      check("err_done", 32'(core_err), 32'd0);
    end else begin
      check("err_timeout", 32'(core_err), 32'd1);
      check("valid_timeout", 32'(core_valid), 32'd0);
    end
    check("rdata", core_rdata, exp_rdata);
    check("memreq_done", 32'(mem_req), 32'd0);
    check("stall_done", 32'(core_stall), 32'd0);
    @(negedge clk);
    check("single_pulse", 32'({core_valid, core_err, core_misaligned}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_size = '0; core_addr = '0; core_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #23;
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_pulses", 32'({core_valid, core_err, core_misaligned, mem_we, core_stall}), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_access(1'b0, DATA_SIZE_BYTE,        32'h0000_0103, 32'h0,         32'h80FF_1234, 3);
    run_access(1'b0, DATA_SIZE_U_HALF_WORD, 32'h0000_0102, 32'h0,         32'h8001_0000, 0);
    run_access(1'b1, DATA_SIZE_BYTE,        32'h0000_0201, 32'hAABB_CCDD, 32'h0,         1);
    run_access(1'b0, DATA_SIZE_WORD,        32'h0000_0102, 32'h0,         32'h0,         0);
    run_access(1'b0, 3'd3,                  32'h0000_0100, 32'h0,         32'h0,         0);
    run_access(1'b0, DATA_SIZE_WORD,        32'h0000_0300, 32'h0,         32'h0,         99);
    run_access(1'b0, DATA_SIZE_HALF_WORD,   32'h0000_0402, 32'h0,         32'hBEEF_0000, TMO - 1);

    // Reset while an access is outstanding.
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_size = DATA_SIZE_WORD; core_addr = 32'h40;
    @(negedge clk);
    check("midrst_pre", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    core_req = 1'b0;
    #1;
    check("midrst_memreq", 32'(mem_req), 32'd0);
    check("midrst_rdata", core_rdata, 32'd0);
    check("midrst_stall", 32'(core_stall), 32'd0);
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_access(1'b1, DATA_SIZE_WORD, 32'h0, 32'h1234_5678, 32'h0, 1);

    for (int i = 0; i < 80; i++) begin
      run_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom, int'($urandom_range(0, TMO + 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
